// File: rtl/noc_fifo_pkg.sv
// Shared definitions for the router input FIFO bank: default sizes, lane indices
// and the occupancy-count width helper.
package noc_fifo_pkg;

   localparam int unsigned DEF_DEPTH    = 8;
   localparam int unsigned DEF_DATASIZE = 40;

   localparam int unsigned PORT_E = 0;
   localparam int unsigned PORT_S = 1;
   localparam int unsigned PORT_W = 2;
   localparam int unsigned PORT_L = 3;

   // One extra bit so a completely full lane (count == depth) is representable.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_lane.sv
// One first-word-fall-through FIFO lane with synchronous flush, almost-full flag
// and a sticky overflow error.
module fifo_lane
   import noc_fifo_pkg::*;
#(
   parameter int unsigned  DEPTH     = DEF_DEPTH,
   parameter int unsigned  DATASIZE  = DEF_DATASIZE,
   parameter int unsigned  AF_THRESH = 6,
   localparam int unsigned PTR_W     = $clog2(DEPTH),
   localparam int unsigned CNT_W     = cnt_width(DEPTH)
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [DATASIZE-1:0] i_data,
   input  logic                i_valid,
   input  logic                i_ready,
   input  logic                i_flush,
   output logic [DATASIZE-1:0] o_data,
   output logic                o_valid,
   output logic                o_full,
   output logic                o_almost_full,
   output logic [CNT_W-1:0]    o_count,
   output logic                o_ovf
);

   logic [DATASIZE-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [CNT_W-1:0]    r_count;
   logic                r_ovf;

   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_push;
   logic w_drop;

   // A full lane still accepts a write when its head leaves in the same cycle;
   // flush swallows any write without flagging it as overflow.
   always_comb begin
      w_empty = (r_count == '0);
      w_full  = (r_count == CNT_W'(DEPTH));
      w_pop   = i_ready & ~w_empty;
      w_push  = i_valid & (~w_full | w_pop) & ~i_flush;
      w_drop  = i_valid & w_full & ~w_pop & ~i_flush;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ovf <= 1'b0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_data        = w_empty ? '0 : r_mem[r_rd_ptr];
   assign o_valid       = ~w_empty;
   assign o_full        = w_full;
   assign o_almost_full = (r_count >= CNT_W'(AF_THRESH));
   assign o_count       = r_count;
   assign o_ovf         = r_ovf;

endmodule

// File: rtl/fifo_port_array.sv
// Bank of NUM_PORTS independent FWFT lanes on packed buses; per-lane occupancy
// is exported as pressure for the adaptive-routing arbiter.
module fifo_port_array
   import noc_fifo_pkg::*;
#(
   parameter int unsigned  NUM_PORTS = 4,
   parameter int unsigned  DEPTH     = DEF_DEPTH,
   parameter int unsigned  DATASIZE  = DEF_DATASIZE,
   parameter int unsigned  AF_THRESH = 6,
   localparam int unsigned PTR_W     = $clog2(DEPTH),
   localparam int unsigned CNT_W     = cnt_width(DEPTH)
) (
   input  logic                            fifo_clk,
   input  logic                            rst,
   input  logic [NUM_PORTS*DATASIZE-1:0]   data_in,
   input  logic [NUM_PORTS-1:0]            valid_in,
   input  logic [NUM_PORTS-1:0]            ready_in,
   input  logic [NUM_PORTS-1:0]            flush,
   output logic [NUM_PORTS*DATASIZE-1:0]   data_out,
   output logic [NUM_PORTS-1:0]            valid_out,
   output logic [NUM_PORTS-1:0]            full_out,
   output logic [NUM_PORTS-1:0]            almost_full_out,
   output logic [NUM_PORTS*(PTR_W+1)-1:0]  pressure_out,
   output logic [NUM_PORTS-1:0]            ovf_err
);

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
      fifo_lane #(
         .DEPTH     (DEPTH),
         .DATASIZE  (DATASIZE),
         .AF_THRESH (AF_THRESH)
      ) u_lane (
         .i_clk         (fifo_clk),
         .i_rst         (rst),
         .i_data        (data_in[p*DATASIZE +: DATASIZE]),
         .i_valid       (valid_in[p]),
         .i_ready       (ready_in[p]),
         .i_flush       (flush[p]),
         .o_data        (data_out[p*DATASIZE +: DATASIZE]),
         .o_valid       (valid_out[p]),
         .o_full        (full_out[p]),
         .o_almost_full (almost_full_out[p]),
         .o_count       (pressure_out[p*CNT_W +: CNT_W]),
         .o_ovf         (ovf_err[p])
      );
   end

endmodule

// File: doc/fifo_port_array.md
Name: fifo_port_array

Overview:
- Parametrised successor to the fixed four-direction router input FIFO bank.
- NUM_PORTS independent first-word-fall-through lanes on packed buses. Intended for use with any router radix: E/S/W/L, N/E/S/W/L, or express links.
- Adds behaviour the previous bank lacked: push-while-full when a pop happens in the same cycle, a programmable almost-full flag, a per-lane synchronous flush, and a sticky overflow error per lane.
- Each lane's occupancy is exported as pressure for the adaptive-routing arbiter.

Parameters:
- NUM_PORTS, 4: number of independent lanes (>=1).
- DEPTH, 8: entries per lane; power of two, >=2.
- DATASIZE, 40: flit width in bits.
- AF_THRESH, 6: almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
- PTR_W, $clog2(DEPTH): localparam, not overridable. Count width is PTR_W+1.

Ports:
- fifo_clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- data_in  in  NUM_PORTS*DATASIZE  lane p occupies [p*DATASIZE +: DATASIZE].
- valid_in  in  NUM_PORTS  per-lane write request.
- ready_in  in  NUM_PORTS  per-lane downstream ready (read request).
- flush  in  NUM_PORTS  per-lane synchronous clear.
- data_out  out  NUM_PORTS*DATASIZE  head flit per lane; 0 when the lane is empty.
- valid_out  out  NUM_PORTS  lane non-empty.
- full_out  out  NUM_PORTS  count == DEPTH.
- almost_full_out  out  NUM_PORTS  count >= AF_THRESH.
- pressure_out  out  NUM_PORTS*(PTR_W+1)  lane count at [p*(PTR_W+1) +: PTR_W+1].
- ovf_err  out  NUM_PORTS  sticky: a write was dropped on this lane.

Behaviour:
- Reset (rst=1, asynchronous): every lane's wr_ptr, rd_ptr and count go to 0. All outputs read 0: valid_out, full_out, almost_full_out, pressure_out, ovf_err and data_out. The storage array is not reset.
- Per-lane signal definitions, all lanes independent:
  - pop = ready_in & valid_out.
  - push = valid_in & (~full_out | pop). A write into a full lane is accepted when a pop happens in the same cycle.
  - drop = valid_in & full_out & ~pop. The flit is discarded and ovf_err sets; ovf_err clears only on rst.
- Count update: count_next = count + push - pop. Width is PTR_W+1, so DEPTH itself is representable.
- Pointers are PTR_W bits and wrap naturally from DEPTH-1 to 0.
  - Write: mem[wr_ptr] <= data_in on push.
  - Read: rd_ptr advances on pop.
- First-word fall-through:
  - data_out = mem[rd_ptr], combinational from storage, gated to 0 when count == 0.
  - Latency from a push at edge N to valid_out=1 is one cycle, i.e. visible after edge N.
- Empty lane with push and ready_in both high: no pop, because valid_out=0. The flit is stored and presented in the next cycle; there is no bypass.
- Flush has highest priority over push and pop.
  - At the edge, wr_ptr, rd_ptr and count clear to 0. Any same-cycle push is discarded and is not counted as overflow.
  - ovf_err is unaffected by flush.
- All flags (full_out, almost_full_out, valid_out) and pressure_out are decoded from the registered count. They change only after a clock edge.
- AF_THRESH == DEPTH makes almost_full_out identical to full_out.
- Reset asserted mid-transfer: state clears immediately; in-flight data is lost. After deassertion, the first edge behaves as from empty.

Decomposition:
- Shared package noc_fifo_pkg holds:
  - localparams DEF_DEPTH=8 and DEF_DATASIZE=40;
  - a function for the count width, clog2(DEPTH)+1;
  - lane index constants PORT_E=0, PORT_S=1, PORT_W=2, PORT_L=3.
- Sub-module fifo_lane implements one FWFT lane with flush, almost-full and overflow.
- fifo_port_array instantiates NUM_PORTS copies of fifo_lane in a generate loop and does the slicing of the packed buses.

Test Plan:
- Reset and fill: rst pulse, then valid_in[0]=1 for 8 cycles with data 1..8, ready_in=0.
  - After edge 6: almost_full_out[0]=1 and pressure=6.
  - After edge 8: full_out[0]=1 and pressure=8.
  - data_out[0] stays 1 throughout; other lanes remain 0.
- Full with simultaneous push/pop: lane 0 full, valid_in=1 with data 9, ready_in=1 for one cycle.
  - Flit 1 leaves, 9 is accepted, pressure stays 8, ovf_err=0.
- Overflow: lane 0 full, ready_in=0, valid_in=1 with data 10.
  - Flit dropped, ovf_err[0]=1, pressure stays 8.
  - Drain with ready_in=1 yields 2..9 in order. ovf_err[0] stays 1 until rst.
- Flush priority: lane 2 holds 3 flits; flush[2]=1 with valid_in[2]=1 in the same cycle.
  - Next cycle: pressure=0, valid_out[2]=0, data_out[2]=0, ovf_err[2]=0.
- Lane independence and wrap: NUM_PORTS=5, DEPTH=4. Stream 20 flits through lane 4 with ready_in toggling 1/0.
  - Output order and data are exact with no loss across pointer wrap.
  - Lanes 0-3 unchanged.
- Async reset mid-operation: assert rst between clock edges while lanes are half full.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - The first push after release appears on data_out one cycle later.
